axis_traffic_gen: RTL and testbench
===================================

// Module: axis_traffic_gen
// PURPOSE
// Configurable AXI-Stream traffic source for NoC bring-up and stress tests; next generation of our LFSR number generator.
// Emits CFG_NUM_PKTS packets of CFG_PKT_LEN beats, spreading destinations round-robin over an enable mask.
// Payload is either an LFSR sequence or an incrementing counter.
// Honours full AXIS backpressure. Sits at a router local port, feeding the NoC injection interface.
// PARAMETERS
// TDATAW     32       AXIS data width
// TDESTW     4        AXIS dest width; NUM_DEST <= 2**TDESTW
// TIDW       2        AXIS id width
// NUM_DEST   4        number of reachable destinations (mask width)
// PKT_LEN_W  8        width of packet-length config
// LFSR_W     16       LFSR width (8/16/32 supported)
// LFSR_SEED  16'hACE1 LFSR load value; a zero seed is replaced by 1
// SRC_ID     0        constant driven on TID
// PORTS
// CLK            in   1          clock
// RST_N          in   1          async active-low reset
// START          in   1          1-cycle start pulse; ignored unless idle
// STOP           in   1          1-cycle stop request; honoured at next packet boundary
// CFG_MODE       in   1          0 = LFSR payload, 1 = incrementing payload
// CFG_PKT_LEN    in   PKT_LEN_W  beats per packet; 0 treated as 1
// CFG_NUM_PKTS   in   16         packets per run; 0 = run until STOP
// CFG_DEST_MASK  in   NUM_DEST   enabled destinations; all-zero treated as 'b1
// BUSY           out  1          run in progress
// DONE           out  1          1-cycle pulse at end of run
// SENT_PKTS      out  16         packets completed in the current/last run; wraps
// AXIS_M_TVALID/TREADY/TDATA[TDATAW]/TLAST/TID[TIDW]/TDEST[TDESTW]   AXIS master
// BEHAVIOUR
// - Clock/reset: clock CLK; reset RST_N, asynchronous, active-low.
// - Reset values: all outputs 0; FSM in IDLE; LFSR = seed.
// - A reset mid-run drops TVALID immediately; no partial packet is resumed.
// - FSM IDLE -> SEND on START. On START, latch all CFG_*, clear the packet/beat/sequence counters and SENT_PKTS.
// - On START, also reload the LFSR seed, clear stop_pend, and set dest = lowest set mask bit.
// - SEND: TVALID = 1. A fire is TVALID & TREADY.
// - While TVALID & !TREADY, TDATA/TDEST/TLAST/TID are held stable and TVALID is not withdrawn.
// - Timing: first beat is valid the cycle after START. Throughput is 1 beat/cycle while TREADY = 1.
// - TLAST = (beat_cnt == len-1). On a fire with TLAST: SENT_PKTS++, beat_cnt = 0.
// - On that same TLAST fire, dest advances to the next set mask bit above current, wrapping to the lowest.
// - SEND -> FIN on a TLAST fire if (NUM_PKTS != 0 && SENT_PKTS+1 == NUM_PKTS) or stop_pend (including a STOP in that same cycle).
// - FIN: TVALID = 0, DONE = 1 for one cycle, then -> IDLE. BUSY = 1 in SEND and FIN.
// - STOP in SEND sets stop_pend and never truncates a packet. STOP in IDLE/FIN is ignored. START outside IDLE is ignored.
// - Payload: TDATA = zero-extended payload (truncated if LFSR_W > TDATAW).
// - LFSR mode: payload = LFSR state. The LFSR steps only on a fire (not free-running).
// - INCR mode: payload = sequence counter, 0 at START, +1 per fire, wraps mod 2**TDATAW.
// - TDEST = zero-extended dest index. TID = SRC_ID.
// - LFSR is Fibonacci, maximal-length; taps come from the package.
// STRUCTURE
// - traffic_gen_pkg holds:
//   - state_t {IDLE, SEND, FIN}
//   - mode_t {MODE_LFSR, MODE_INCR}
//   - function lfsr_taps(width) for 8/16/32
//   - function next_dest(mask, cur) implementing the round-robin pick
// - Sub-module tg_lfsr (params W, SEED; ports CLK, RST_N, LOAD, EN, Q): loadable, enable-gated.
// - The top holds the FSM, counters, output registers and the dest selector.
// TESTING
// 1 Reset: RST_N low -> TVALID/TLAST/BUSY/DONE/SENT_PKTS = 0. START during reset has no effect.
// 2 INCR, LEN=4, NUM=2, mask 4'b0101, TREADY=1 -> TDATA 0..7, TLAST on beats 3,7, TDEST 0,0,0,0,2,2,2,2;
//   DONE on the cycle after beat 7; SENT_PKTS = 2.
// 3 Repeat test 2 with TREADY random, plus TREADY low for 5 cycles mid-packet -> identical beat sequence,
//   outputs stable under stall, no drop or duplicate.
// 4 LFSR, W=16, seed ACE1, LEN=3, NUM=3 -> 9 beats match the model LFSR stepped per fire;
//   a second START reproduces the identical sequence.
// 5 NUM=0, LEN=4, STOP on beat 1 -> packet finishes with TLAST, DONE pulses, no further TVALID.
//   Also STOP coinciding with a TLAST fire -> FIN right after that beat.
// 6 LEN=0 and LEN=1 -> every beat TLAST. Mask 0 -> all TDEST = 0.
//   RST_N pulse mid-packet -> TVALID drops async; the next START restarts at data 0 / lowest dest.

Source files
------------

// File: rtl/traffic_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_gen_pkg
//  Brief    : Shared types, LFSR tap table and round-robin destination picker
//             for the AXI-Stream traffic generator.
//  Revision : 1.0 - initial release
// ============================================================================
package traffic_gen_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        FIN  = 2'd2
    } state_t;

    typedef enum logic {
        MODE_LFSR = 1'b0,
        MODE_INCR = 1'b1
    } mode_t;

    localparam int c_MAX_DEST = 32;
    localparam int c_IDX_W    = 5;

    // Fibonacci taps (bit i set = state bit i feeds the XOR); all maximal-length.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] w_taps;
        case (width)
            8:       w_taps = 32'h0000_00B8;
            16:      w_taps = 32'h0000_B400;
            32:      w_taps = 32'h8020_0003;
            default: w_taps = 32'h0000_0000;
        endcase
        return w_taps;
    endfunction

    function automatic logic [c_IDX_W-1:0] first_dest(input logic [c_MAX_DEST-1:0] mask);
        logic [c_IDX_W-1:0] w_res;
        w_res = '0;
        for (int i = c_MAX_DEST - 1; i >= 0; i--) begin
            if (mask[i]) begin
                w_res = c_IDX_W'(i);
            end
        end
        return w_res;
    endfunction

    // Lowest set bit strictly above cur; wraps to the lowest set bit overall.
    function automatic logic [c_IDX_W-1:0] next_dest(input logic [c_MAX_DEST-1:0] mask,
                                                     input logic [c_IDX_W-1:0]    cur);
        logic [c_IDX_W-1:0] w_res;
        w_res = first_dest(mask);
        for (int i = c_MAX_DEST - 1; i >= 0; i--) begin
            if (mask[i] && (c_IDX_W'(i) > cur)) begin
                w_res = c_IDX_W'(i);
            end
        end
        return w_res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_traffic_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : axis_traffic_gen_if
//  Brief    : AXI-Stream bundle with master/slave views.
//  Revision : 1.0 - initial release
// ============================================================================
interface axis_traffic_gen_if #(
    parameter int TDATAW = 32,
    parameter int TDESTW = 4,
    parameter int TIDW   = 2
) ();
    logic              TVALID;
    logic              TREADY;
    logic [TDATAW-1:0] TDATA;
    logic              TLAST;
    logic [TIDW-1:0]   TID;
    logic [TDESTW-1:0] TDEST;

    modport master (
        output TVALID, TDATA, TLAST, TID, TDEST,
        input  TREADY
    );

    modport slave (
        input  TVALID, TDATA, TLAST, TID, TDEST,
        output TREADY
    );
endinterface
`default_nettype wire

// File: rtl/tg_lfsr.sv
`default_nettype none
// ============================================================================
//  Module   : tg_lfsr
//  Brief    : Loadable, enable-gated Fibonacci LFSR (8/16/32 bit).
//  Revision : 1.0 - initial release
// ============================================================================
module tg_lfsr
    import traffic_gen_pkg::*;
#(
    parameter int           W    = 16,
    parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
    input  wire logic         CLK,
    input  wire logic         RST_N,
    input  wire logic         LOAD,
    input  wire logic         EN,
    output logic [W-1:0]      Q
);
    // An all-zero state would lock the register up.
    localparam logic [W-1:0] c_SEED = (SEED == '0) ? W'(1) : SEED;
    localparam logic [W-1:0] c_TAPS = W'(lfsr_taps(W));

    logic w_fb;

    assign w_fb = ^(Q & c_TAPS);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            Q <= c_SEED;
        end else if (LOAD) begin
            Q <= c_SEED;
        end else if (EN) begin
            Q <= {Q[W-2:0], w_fb};
        end
    end
endmodule
`default_nettype wire

// File: rtl/axis_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : axis_traffic_gen
//  Brief    : AXI-Stream traffic source: fixed-length packets, round-robin
//             destinations, LFSR or incrementing payload, full backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_traffic_gen
    import traffic_gen_pkg::*;
#(
    parameter int                TDATAW    = 32,
    parameter int                TDESTW    = 4,
    parameter int                TIDW      = 2,
    parameter int                NUM_DEST  = 4,
    parameter int                PKT_LEN_W = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_W'(16'hACE1),
    parameter int                SRC_ID    = 0
) (
    input  wire logic                 CLK,
    input  wire logic                 RST_N,
    input  wire logic                 START,
    input  wire logic                 STOP,
    input  wire logic                 CFG_MODE,
    input  wire logic [PKT_LEN_W-1:0] CFG_PKT_LEN,
    input  wire logic [15:0]          CFG_NUM_PKTS,
    input  wire logic [NUM_DEST-1:0]  CFG_DEST_MASK,
    output logic                      BUSY,
    output logic                      DONE,
    output logic [15:0]               SENT_PKTS,
    axis_traffic_gen_if.master        AXIS_M
);

    state_t                r_state;
    state_t                w_state_nxt;
    mode_t                 r_mode;
    logic [PKT_LEN_W-1:0]  r_len_m1;
    logic [PKT_LEN_W-1:0]  r_beat;
    logic [15:0]           r_num;
    logic [15:0]           r_sent;
    logic [NUM_DEST-1:0]   r_mask;
    logic [c_IDX_W-1:0]    r_dest;
    logic [TDATAW-1:0]     r_seq;
    logic                  r_stop_pend;

    logic                  w_start;
    logic                  w_valid;
    logic                  w_last;
    logic                  w_fire;
    logic                  w_last_fire;
    logic                  w_run_end;
    logic                  w_fin;
    logic [NUM_DEST-1:0]   w_mask_eff;
    logic [LFSR_W-1:0]     w_lfsr_q;
    logic [TDATAW-1:0]     w_lfsr_data;
    logic [TDATAW-1:0]     w_payload;

    assign w_start     = START && (r_state == IDLE);
    assign w_valid     = (r_state == SEND);
    assign w_last      = (r_beat == r_len_m1);
    assign w_fire      = w_valid && AXIS_M.TREADY;
    assign w_last_fire = w_fire && w_last;
    assign w_run_end   = ((r_num != 16'd0) && ((r_sent + 16'd1) == r_num)) || r_stop_pend || STOP;
    assign w_fin       = w_last_fire && w_run_end;
    assign w_mask_eff  = (CFG_DEST_MASK == '0) ? NUM_DEST'(1) : CFG_DEST_MASK;

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        BUSY        = 1'b0;
        DONE        = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (START) begin
                    w_state_nxt = SEND;
                end
            end
            SEND: begin
                BUSY = 1'b1;
                if (w_fin) begin
                    w_state_nxt = FIN;
                end
            end
            FIN: begin
                BUSY        = 1'b1;
                DONE        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------ datapath
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_mode      <= MODE_LFSR;
            r_len_m1    <= '0;
            r_beat      <= '0;
            r_num       <= '0;
            r_sent      <= '0;
            r_mask      <= '0;
            r_dest      <= '0;
            r_seq       <= '0;
            r_stop_pend <= 1'b0;
        end else if (w_start) begin
            r_mode      <= mode_t'(CFG_MODE);
            r_len_m1    <= (CFG_PKT_LEN == '0) ? '0 : CFG_PKT_LEN - PKT_LEN_W'(1);
            r_num       <= CFG_NUM_PKTS;
            r_mask      <= w_mask_eff;
            r_beat      <= '0;
            r_sent      <= '0;
            r_seq       <= '0;
            r_stop_pend <= 1'b0;
            r_dest      <= first_dest(c_MAX_DEST'(w_mask_eff));
        end else if (r_state == SEND) begin
            if (STOP) begin
                r_stop_pend <= 1'b1;
            end
            if (w_fire) begin
                r_seq <= r_seq + TDATAW'(1);
                if (w_last) begin
                    r_beat <= '0;
                    r_sent <= r_sent + 16'd1;
                    r_dest <= next_dest(c_MAX_DEST'(r_mask), r_dest);
                end else begin
                    r_beat <= r_beat + PKT_LEN_W'(1);
                end
            end
        end
    end

    // --------------------------------------------------------------- payload
    tg_lfsr #(
        .W    (LFSR_W),
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .CLK   (CLK),
        .RST_N (RST_N),
        .LOAD  (w_start),
        .EN    (w_fire),
        .Q     (w_lfsr_q)
    );

    generate
        if (LFSR_W >= TDATAW) begin : g_lfsr_trunc
            assign w_lfsr_data = w_lfsr_q[TDATAW-1:0];
        end else begin : g_lfsr_zext
            assign w_lfsr_data = {{(TDATAW-LFSR_W){1'b0}}, w_lfsr_q};
        end
    endgenerate

    assign w_payload = (r_mode == MODE_INCR) ? r_seq : w_lfsr_data;

    // Beat fields are pure functions of registers, so they hold under stall.
    assign AXIS_M.TVALID = w_valid;
    assign AXIS_M.TDATA  = w_valid ? w_payload : '0;
    assign AXIS_M.TLAST  = w_valid && w_last;
    assign AXIS_M.TDEST  = w_valid ? TDESTW'(r_dest) : '0;
    assign AXIS_M.TID    = TIDW'(SRC_ID);
    assign SENT_PKTS     = r_sent;

endmodule
`default_nettype wire

// File: tb/tb_axis_traffic_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axis_traffic_gen
//  Brief    : Scoreboard bench for axis_traffic_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axis_traffic_gen;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        START = 1'b0;
    logic        STOP = 1'b0;
    logic        CFG_MODE = 1'b0;
    logic [7:0]  CFG_PKT_LEN = 8'd0;
    logic [15:0] CFG_NUM_PKTS = 16'd0;
    logic [3:0]  CFG_DEST_MASK = 4'd0;
    logic        BUSY;
    logic        DONE;
    logic [15:0] SENT_PKTS;

    int errors = 0;
    int checks = 0;

    logic [31:0] q_data[$];
    logic [3:0]  q_dest[$];
    logic        q_last[$];

    axis_traffic_gen_if #(.TDATAW(32), .TDESTW(4), .TIDW(2)) axis ();

    axis_traffic_gen dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .START         (START),
        .STOP          (STOP),
        .CFG_MODE      (CFG_MODE),
        .CFG_PKT_LEN   (CFG_PKT_LEN),
        .CFG_NUM_PKTS  (CFG_NUM_PKTS),
        .CFG_DEST_MASK (CFG_DEST_MASK),
        .BUSY          (BUSY),
        .DONE          (DONE),
        .SENT_PKTS     (SENT_PKTS),
        .AXIS_M        (axis.master)
    );

    always #5 CLK = ~CLK;

    // x^16 + x^14 + x^13 + x^11 + 1, shifting left
    function automatic logic [15:0] lfsr_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    task automatic push_expected(input bit mode, input int len, input int npkts, input logic [3:0] mask);
        int          l;
        int          dl[$];
        logic [15:0] m;
        logic [31:0] seq;
        l = (len == 0) ? 1 : len;
        for (int i = 0; i < 4; i++) if (mask[i]) dl.push_back(i);
        if (dl.size() == 0) dl.push_back(0);
        m   = 16'hACE1;
        seq = 32'd0;
        for (int p = 0; p < npkts; p++) begin
            for (int b = 0; b < l; b++) begin
                q_data.push_back(mode ? seq : {16'h0000, m});
                q_dest.push_back(4'(dl[p % dl.size()]));
                q_last.push_back(b == l - 1);
                seq = seq + 32'd1;
                m   = lfsr_step(m);
            end
        end
    endtask

    // Entered and left just after a falling edge; first beat is then visible.
    task automatic start_run(input bit mode, input int len, input int num, input logic [3:0] mask);
        CFG_MODE      = mode;
        CFG_PKT_LEN   = 8'(len);
        CFG_NUM_PKTS  = 16'(num);
        CFG_DEST_MASK = mask;
        axis.TREADY   = 1'b0;
        START         = 1'b1;
        @(negedge CLK);
        START         = 1'b0;
    endtask

    // rmode: 0 = always ready, 1 = random, 2 = random plus a 5-cycle stall after beat 2.
    task automatic drain(input string name, input int rmode, input int stop_at, input int budget);
        int          fires = 0;
        int          cyc = 0;
        int          last_cyc = -10;
        int          done_cyc = -1;
        int          stall_left = 0;
        bit          stalled_once = 1'b0;
        bit          prev_hold = 1'b0;
        logic [31:0] hd, ed;
        logic [3:0]  hdest, edest;
        logic        hl, el;
        while (cyc < budget && done_cyc < 0) begin
            if (rmode == 0) begin
                axis.TREADY = 1'b1;
            end else begin
                if (rmode == 2 && !stalled_once && fires == 2) begin
                    stall_left   = 5;
                    stalled_once = 1'b1;
                end
                if (stall_left > 0) begin
                    axis.TREADY = 1'b0;
                    stall_left--;
                end else begin
                    axis.TREADY = 1'($urandom_range(0, 1));
                end
            end
            #1;
            if (prev_hold) begin
                checks++;
                if (axis.TVALID !== 1'b1 || axis.TDATA !== hd || axis.TDEST !== hdest || axis.TLAST !== hl) begin
                    errors++;
                    $display("FAIL %s stall_hold: got v=%b d=%h dest=%0d last=%b, need v=1 d=%h dest=%0d last=%b",
                             name, axis.TVALID, axis.TDATA, axis.TDEST, axis.TLAST, hd, hdest, hl);
                end
            end
            prev_hold = (axis.TVALID === 1'b1) && (axis.TREADY === 1'b0);
            hd        = axis.TDATA;
            hdest     = axis.TDEST;
            hl        = axis.TLAST;
            if (axis.TVALID === 1'b1 && axis.TREADY === 1'b1) begin
                checks++;
                if (q_data.size() == 0) begin
                    errors++;
                    $display("FAIL %s extra_beat: got d=%h, need no beat", name, axis.TDATA);
                end else begin
                    ed    = q_data.pop_front();
                    edest = q_dest.pop_front();
                    el    = q_last.pop_front();
                    if (axis.TDATA !== ed || axis.TDEST !== edest || axis.TLAST !== el) begin
                        errors++;
                        $display("FAIL %s beat%0d: got d=%h dest=%0d last=%b, need d=%h dest=%0d last=%b",
                                 name, fires, axis.TDATA, axis.TDEST, axis.TLAST, ed, edest, el);
                    end
                end
                if (fires == stop_at) STOP = 1'b1;
                fires++;
                last_cyc = cyc;
            end
            if (DONE === 1'b1) begin
                done_cyc = cyc;
                checks++;
                if (axis.TVALID !== 1'b0) begin
                    errors++;
                    $display("FAIL %s valid_in_fin: got %b, need 0", name, axis.TVALID);
                end
            end
            @(negedge CLK);
            STOP = 1'b0;
            cyc++;
        end
        checks++;
        if (done_cyc < 0) begin
            errors++;
            $display("FAIL %s done_timeout: got no DONE in %0d cycles, need DONE", name, budget);
        end else if (done_cyc != last_cyc + 1) begin
            errors++;
            $display("FAIL %s done_timing: got cycle %0d, need %0d", name, done_cyc, last_cyc + 1);
        end
        checks++;
        if (q_data.size() != 0) begin
            errors++;
            $display("FAIL %s missing_beats: got %0d unsent, need 0", name, q_data.size());
        end
        q_data.delete();
        q_dest.delete();
        q_last.delete();
        for (int k = 0; k < 3; k++) begin
            axis.TREADY = 1'b1;
            #1;
            checks++;
            if (axis.TVALID !== 1'b0 || DONE !== 1'b0 || BUSY !== 1'b0) begin
                errors++;
                $display("FAIL %s post_run: got v=%b done=%b busy=%b, need 0/0/0", name, axis.TVALID, DONE, BUSY);
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b1;
        CFG_MODE = 1'b1; CFG_PKT_LEN = 8'd4; CFG_NUM_PKTS = 16'd1; CFG_DEST_MASK = 4'b0001;
        axis.TREADY = 1'b1;
        @(negedge CLK);
        @(negedge CLK);
        checks++; if (axis.TVALID !== 1'b0) begin errors++; $display("FAIL rst_tvalid: got %b, need 0", axis.TVALID); end
        checks++; if (axis.TLAST !== 1'b0) begin errors++; $display("FAIL rst_tlast: got %b, need 0", axis.TLAST); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, need 0", BUSY); end
        checks++; if (DONE !== 1'b0) begin errors++; $display("FAIL rst_done: got %b, need 0", DONE); end
        checks++; if (SENT_PKTS !== 16'd0) begin errors++; $display("FAIL rst_sent: got %0d, need 0", SENT_PKTS); end
        checks++; if (axis.TID !== 2'd0) begin errors++; $display("FAIL rst_tid: got %0d, need 0", axis.TID); end
        RST_N = 1'b1;
        START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        checks++;
        if (BUSY !== 1'b0 || axis.TVALID !== 1'b0) begin
            errors++;
            $display("FAIL rst_start_ignored: got busy=%b v=%b, need 0/0", BUSY, axis.TVALID);
        end
    endtask

    task automatic test_incr();
        push_expected(1'b1, 4, 2, 4'b0101);
        start_run(1'b1, 4, 2, 4'b0101);
        checks++;
        if (axis.TVALID !== 1'b1 || axis.TDATA !== 32'd0) begin
            errors++;
            $display("FAIL incr_first_beat: got v=%b d=%h, need v=1 d=0", axis.TVALID, axis.TDATA);
        end
        drain("incr", 0, -1, 60);
        checks++; if (SENT_PKTS !== 16'd2) begin errors++; $display("FAIL incr_sent: got %0d, need 2", SENT_PKTS); end
    endtask

    task automatic test_backpressure();
        push_expected(1'b1, 4, 2, 4'b0101);
        start_run(1'b1, 4, 2, 4'b0101);
        drain("backpressure", 2, -1, 300);
        checks++; if (SENT_PKTS !== 16'd2) begin errors++; $display("FAIL bp_sent: got %0d, need 2", SENT_PKTS); end
    endtask

    task automatic test_lfsr();
        for (int r = 0; r < 2; r++) begin
            push_expected(1'b0, 3, 3, 4'b1111);
            start_run(1'b0, 3, 3, 4'b1111);
            drain((r == 0) ? "lfsr_run1" : "lfsr_run2", 1, -1, 200);
            checks++; if (SENT_PKTS !== 16'd3) begin errors++; $display("FAIL lfsr_sent: got %0d, need 3", SENT_PKTS); end
        end
    endtask

    task automatic test_stop();
        push_expected(1'b1, 4, 1, 4'b0011);
        start_run(1'b1, 4, 0, 4'b0011);
        drain("stop_mid", 0, 1, 60);
        checks++; if (SENT_PKTS !== 16'd1) begin errors++; $display("FAIL stop_mid_sent: got %0d, need 1", SENT_PKTS); end
        push_expected(1'b1, 2, 2, 4'b0011);
        start_run(1'b1, 2, 0, 4'b0011);
        drain("stop_on_last", 0, 3, 60);
        checks++; if (SENT_PKTS !== 16'd2) begin errors++; $display("FAIL stop_last_sent: got %0d, need 2", SENT_PKTS); end
    endtask

    task automatic test_len_mask();
        push_expected(1'b1, 0, 3, 4'b0000);
        start_run(1'b1, 0, 3, 4'b0000);
        drain("len0_mask0", 1, -1, 100);
        push_expected(1'b1, 1, 2, 4'b1000);
        start_run(1'b1, 1, 2, 4'b1000);
        drain("len1_mask8", 0, -1, 60);
    endtask

    task automatic test_reset_mid();
        start_run(1'b1, 4, 2, 4'b0110);
        axis.TREADY = 1'b1;
        @(negedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (axis.TVALID !== 1'b0) begin errors++; $display("FAIL midrst_tvalid: got %b, need 0", axis.TVALID); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b, need 0", BUSY); end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        push_expected(1'b1, 4, 2, 4'b0110);
        start_run(1'b1, 4, 2, 4'b0110);
        drain("after_midrst", 1, -1, 200);
    endtask

    initial begin
        axis.TREADY = 1'b0;
        @(negedge CLK);
        test_reset();
        test_incr();
        test_backpressure();
        test_lfsr();
        test_stop();
        test_len_mask();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, need completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
